// File: rtl/source_deframer.sv
// -----------------------------------------------------------------------------
// source_config / source_deframer
//
// source_config holds the shared source-side widths. The SPK payload is a
// destination index (clog2 of the input count) followed by a charge value.
//
// source_deframer turns the host byte stream into instruction words for
// network_source. The first byte's top OPC_WIDTH bits select the opcode, and
// the opcode fixes the frame length. Bytes are packed MSB-first into a frame
// buffer. A completed frame is presented left-aligned on src with a
// valid/ready handshake. NOP frames are swallowed.
//
// Ports
//   clk        in   1          rising-edge clock
//   arstn      in   1          asynchronous active-low reset
//   rx_valid   in   1          byte stream valid
//   rx_ready   out  1          byte stream ready (low while a word is pending)
//   rx_data    in   8          byte stream data
//   src_valid  out  1          instruction word valid
//   src_ready  in   1          instruction word accepted downstream
//   src        out  SRC_WIDTH  instruction word, opcode in the MSBs
// -----------------------------------------------------------------------------
package source_config;
  localparam int NET_NUM_INP      = 4;
  localparam int NET_CHARGE_WIDTH = 8;
  localparam int SPK_WIDTH        = $clog2(NET_NUM_INP) + NET_CHARGE_WIDTH;
  localparam int OPC_WIDTH        = 2;
endpackage

module source_deframer #(
  parameter  int RUN_WIDTH = 8,
  parameter  int SPK_WIDTH = source_config::SPK_WIDTH,
  parameter  int OPC_WIDTH = source_config::OPC_WIDTH,
  localparam int PAY_WIDTH = (RUN_WIDTH > SPK_WIDTH) ? RUN_WIDTH : SPK_WIDTH,
  localparam int SRC_WIDTH = OPC_WIDTH + PAY_WIDTH,
  localparam int NB        = (SRC_WIDTH + 7) / 8
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic [7:0]           rx_data,
  output logic                 src_valid,
  input  logic                 src_ready,
  output logic [SRC_WIDTH-1:0] src
);

  localparam int RUN_LEN = (OPC_WIDTH + RUN_WIDTH + 7) / 8;
  localparam int SPK_LEN = (OPC_WIDTH + SPK_WIDTH + 7) / 8;
  localparam int LEN_W   = $clog2(NB + 1);

  localparam logic [OPC_WIDTH-1:0] OPC_NOP = OPC_WIDTH'(0);
  localparam logic [OPC_WIDTH-1:0] OPC_RUN = OPC_WIDTH'(1);
  localparam logic [OPC_WIDTH-1:0] OPC_SPK = OPC_WIDTH'(2);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       byte_idx_q, byte_idx_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [NB*8-1:0]        frame_buf_q;
  logic [NB*8-1:0]        asm_buf;
  logic [OPC_WIDTH-1:0]   asm_opc;
  logic [LEN_W-1:0]       first_len;
  logic [LEN_W-1:0]       cur_idx;
  logic                   accept;
  logic                   complete;
  logic                   load;

  // Frame length in bytes for a given opcode. NOP and CLR carry no payload.
  function automatic logic [LEN_W-1:0] frame_len(input logic [OPC_WIDTH-1:0] opc);
    logic [LEN_W-1:0] n;
    n = LEN_W'(1);
    if (opc == OPC_RUN) n = LEN_W'(RUN_LEN);
    else if (opc == OPC_SPK) n = LEN_W'(SPK_LEN);
    return n;
  endfunction

  // The byte stream only stalls on the output register. Keeping rx_valid out of
  // this term avoids a combinational loop back to the upstream source.
  assign rx_ready = !src_valid || src_ready;
  assign accept   = rx_valid && rx_ready;

  // Build the frame as it looks once the current byte is included. A first byte
  // starts from an all-zero buffer, so bytes that are never received read as
  // zero. The completed word can then be taken directly from asm_buf in the
  // same cycle as the final byte.
  always_comb begin
    cur_idx = (state_q == IDLE) ? '0 : byte_idx_q;
    asm_buf = (state_q == IDLE) ? '0 : frame_buf_q;
    for (int i = 0; i < NB; i++) begin
      if (cur_idx == LEN_W'(i)) asm_buf[NB*8-1-8*i -: 8] = rx_data;
    end
    asm_opc   = asm_buf[NB*8-1 -: OPC_WIDTH];
    first_len = frame_len(rx_data[7 -: OPC_WIDTH]);
  end

  // Next-state logic: 1-byte frames finish straight from IDLE. Longer frames
  // latch their length and count bytes in COLLECT.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    len_d      = len_q;
    complete   = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (first_len == LEN_W'(1)) begin
            complete = 1'b1;
          end else begin
            len_d      = first_len;
            byte_idx_d = LEN_W'(1);
            state_d    = COLLECT;
          end
        end
        COLLECT: begin
          if (byte_idx_q == len_q - LEN_W'(1)) begin
            complete   = 1'b1;
            byte_idx_d = '0;
            state_d    = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + LEN_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    load = complete && (asm_opc != OPC_NOP);
  end

  // FSM state, counters and frame buffer.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= IDLE;
      byte_idx_q  <= '0;
      len_q       <= '0;
      frame_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      len_q      <= len_d;
      if (accept) frame_buf_q <= asm_buf;
    end
  end

  // One-entry output register. A new load takes priority over the handshake
  // clearing valid. This lets a word be replaced in the cycle it is accepted,
  // with no bubble.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      src_valid <= 1'b0;
      src       <= '0;
    end else if (load) begin
      src_valid <= 1'b1;
      src       <= asm_buf[NB*8-1 -: SRC_WIDTH];
    end else if (src_ready) begin
      src_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_source_deframer.sv
// -----------------------------------------------------------------------------
// tb_source_deframer
//
// Scoreboarded bench for source_deframer in its default configuration
// (SRC_WIDTH=12, NB=2). Each frame's expected word is pushed when its last
// byte is accepted. The monitor pops and compares at every output handshake.
// -----------------------------------------------------------------------------
module tb_source_deframer;

  logic        clk;
  logic        arstn;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        src_valid;
  logic        src_ready;
  logic [11:0] src;

  int          vectors;
  int          miscompares;
  int          cycleCount;
  int          validCycles;
  int          readyMode;
  int          hsCycles[$];
  logic [11:0] expQ[$];

  source_deframer dut (
    .clk       (clk),
    .arstn     (arstn),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src       (src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Compare one value against its expectation and keep the tallies.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one byte until it is accepted, with a bounded number of retries.
  task automatic applyStimulus(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      #1;
      if (rx_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
    end
    if (!ok) checkOutput("rx_accept_timeout", 32'(ok), 32'd1);
  endtask

  // Send a whole frame. The expected word is the top 12 bits of the frame
  // packed MSB-first, with absent bytes treated as zero. NOPs expect nothing.
  task automatic sendFrame(input logic [7:0] b0, input logic [7:0] b1, input int n);
    logic [15:0] w;
    applyStimulus(b0);
    if (n == 2) applyStimulus(b1);
    w = {b0, (n == 2) ? b1 : 8'h00};
    if (b0[7:6] != 2'b00) expQ.push_back(w[15:4]);
  endtask

  task automatic waitDrain(input string tag);
    for (int t = 0; t < 2000 && expQ.size() != 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput(tag, 32'(expQ.size()), 32'd0);
  endtask

  // Downstream ready: forced high, forced low, or random.
  initial begin
    src_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (readyMode)
        0:       src_ready = 1'b0;
        1:       src_ready = 1'b1;
        default: src_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Output monitor. It samples between edges: a handshake seen here completes
  // at the next rising edge.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (arstn && src_valid) validCycles++;
      if (arstn && src_valid && src_ready) begin
        hsCycles.push_back(cycleCount);
        if (expQ.size() == 0) begin
          checkOutput("spurious_word_sb_size", 32'(expQ.size()), 32'd1);
        end else begin
          e = expQ.pop_front();
          checkOutput("word", {20'b0, src}, {20'b0, e});
        end
      end
    end
  end

  initial begin
    int v0, h0;
    logic [1:0] opc;
    logic [7:0] b0, b1;
    vectors     = 0;
    miscompares = 0;
    cycleCount  = 0;
    validCycles = 0;
    readyMode   = 1;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    arstn       = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("reset_src_valid", 32'(src_valid), 32'd0);
    checkOutput("reset_src", {20'b0, src}, 32'h0);
    checkOutput("reset_rx_ready", 32'(rx_ready), 32'd1);
    @(negedge clk);
    arstn = 1'b1;

    // RUN frame, valid held for a single cycle
    $display("[TB] RUN frame");
    v0 = validCycles;
    sendFrame(8'h41, 8'h40, 2);
    waitDrain("run_drain");
    checkOutput("run_valid_cycles", 32'(validCycles - v0), 32'd1);

    // SPK followed directly by CLR, no bubble between words
    $display("[TB] SPK then CLR");
    sendFrame(8'hAF, 8'hD0, 2);
    sendFrame(8'hC0, 8'h00, 1);
    waitDrain("spk_clr_drain");
    checkOutput("spk_clr_no_bubble", 32'(hsCycles[$] - hsCycles[$-1]), 32'd1);

    // NOPs vanish
    $display("[TB] NOP filtering");
    h0 = hsCycles.size();
    sendFrame(8'h00, 8'h00, 1);
    sendFrame(8'h00, 8'h00, 1);
    sendFrame(8'hC0, 8'h00, 1);
    waitDrain("nop_drain");
    checkOutput("nop_word_count", 32'(hsCycles.size() - h0), 32'd1);

    // Back-to-back CLR at one word per cycle
    $display("[TB] back-to-back CLR");
    h0 = hsCycles.size();
    repeat (4) sendFrame(8'hC0, 8'h00, 1);
    waitDrain("clr4_drain");
    checkOutput("clr4_word_count", 32'(hsCycles.size() - h0), 32'd4);
    checkOutput("clr4_consecutive", 32'(hsCycles[$] - hsCycles[$-3]), 32'd3);

    // Backpressure: RUN word pending blocks the following SPK bytes
    $display("[TB] backpressure");
    readyMode = 0;
    sendFrame(8'h41, 8'h40, 2);
    fork
      sendFrame(8'hAF, 8'hD0, 2);
      begin
        repeat (3) @(negedge clk);
        #3;
        checkOutput("bp_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("bp_src_valid", 32'(src_valid), 32'd1);
        checkOutput("bp_src_hold", {20'b0, src}, 32'h414);
        readyMode = 1;
      end
    join
    waitDrain("bp_drain");

    // Reset in the middle of a RUN frame
    $display("[TB] reset mid-frame");
    applyStimulus(8'h41);
    @(negedge clk);
    arstn = 1'b0;
    #2;
    checkOutput("midrst_src_valid", 32'(src_valid), 32'd0);
    checkOutput("midrst_rx_ready", 32'(rx_ready), 32'd1);
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    sendFrame(8'hC0, 8'h00, 1);
    waitDrain("midrst_drain");

    // Random soak with gaps on both sides
    $display("[TB] random soak");
    readyMode = 2;
    for (int f = 0; f < 10000; f++) begin
      opc = 2'($urandom_range(0, 3));
      b0  = {opc, 6'($urandom)};
      b1  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      sendFrame(b0, b1, (opc == 2'd1 || opc == 2'd2) ? 2 : 1);
    end
    waitDrain("soak_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
